fwd_scoreboard: RTL and testbench

//  Parametrised forwarding/hazard unit for the pipeline. Tracks destination regs of in-flight

---
 rtl/fwd_scoreboard.sv | 90 +++++++++
 tb/tb_fwd_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight destinations, picks forward sources per read
// port, detects load-use stalls and counts stall cycles.
module fwd_scoreboard #(
  parameter int RW       = 5,
  parameter int DEPTH    = 3,
  parameter int NPORTS   = 2,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_wen_i,
  input  logic                   issue_load_i,
  input  logic [RW-1:0]          issue_dst_i,
  input  logic [NPORTS*RW-1:0]   src_i,
  input  logic [NPORTS-1:0]      src_used_i,
  output logic [NPORTS*SELW-1:0] fwd_sel_o,
  output logic                   hazard_o,
  output logic                   issue_fire_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  logic [DEPTH:1]  v_q, v_d;
  logic [DEPTH:1]  ld_q, ld_d;
  logic [RW-1:0]   dst_q [1:DEPTH];
  logic [RW-1:0]   dst_d [1:DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NPORTS-1:0] blocked;

  // Scan oldest to youngest so the youngest matching stage is the one left standing;
  // readiness is judged only on that stage, never on an older fallback.
  always_comb begin : fwd_select
    logic [RW-1:0] srcP;
    fwd_sel_o = '0;
    blocked   = '0;
    srcP      = '0;
    for (int p = 0; p < NPORTS; p++) begin
      srcP = src_i[p*RW +: RW];
      for (int k = DEPTH; k >= 1; k--) begin
        if (src_used_i[p] && v_q[k] && (dst_q[k] == srcP) && (srcP != '0)) begin
          fwd_sel_o[p*SELW +: SELW] = SELW'(k);
          blocked[p]                = ld_q[k] && (k < LOAD_LAT);
        end
      end
    end
  end

  assign hazard_o     = issue_valid_i & ~flush_i & (|blocked);
  assign issue_fire_o = issue_valid_i & ~hazard_o & ~hold_i & ~flush_i;
  assign stall_cnt_o  = cnt_q;

  always_comb begin
    v_d   = v_q;
    ld_d  = ld_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (!hold_i) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_d[k]   = v_q[k-1];
        ld_d[k]  = ld_q[k-1];
        dst_d[k] = dst_q[k-1];
      end
      v_d[1]   = issue_fire_o & issue_wen_i & (issue_dst_i != '0);
      ld_d[1]  = issue_fire_o & issue_load_i;
      dst_d[1] = issue_dst_i;
      // A flush kills the instr that was in EX, so it must not reach stage 2.
      if (flush_i) v_d[2] = 1'b0;
      if (hazard_o && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) dst_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
      for (int k = 1; k <= DEPTH; k++) dst_q[k] <= dst_d[k];
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with DEPTH=3, LOAD_LAT=2, NPORTS=2, CNT_W=4.
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       issue_valid_i = 1'b0;
  logic       issue_wen_i = 1'b0;
  logic       issue_load_i = 1'b0;
  logic [4:0] issue_dst_i = '0;
  logic [9:0] src_i = '0;
  logic [1:0] src_used_i = '0;
  logic [3:0] fwd_sel_o;
  logic       hazard_o;
  logic       issue_fire_o;
  logic [3:0] stall_cnt_o;

  int total = 0;
  int bad = 0;
  int expCnt;

  fwd_scoreboard #(.RW(5), .DEPTH(3), .NPORTS(2), .LOAD_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_wen_i(issue_wen_i), .issue_load_i(issue_load_i),
    .issue_dst_i(issue_dst_i), .src_i(src_i), .src_used_i(src_used_i),
    .fwd_sel_o(fwd_sel_o), .hazard_o(hazard_o), .issue_fire_o(issue_fire_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one decode slot, then let the combinational outputs settle mid-cycle.
  task automatic applyStimulus(input logic valid, input logic wen, input logic load,
                               input logic [4:0] dst, input logic [4:0] s0,
                               input logic [4:0] s1, input logic [1:0] used);
    issue_valid_i = valid;
    issue_wen_i   = wen;
    issue_load_i  = load;
    issue_dst_i   = dst;
    src_i         = {s1, s0};
    src_used_i    = used;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
    checkOutput("rst_sel", fwd_sel_o, 0);
    checkOutput("rst_haz", hazard_o, 0);
    checkOutput("rst_cnt", stall_cnt_o, 0);
    checkOutput("idle_fire", issue_fire_o, 0);

    // ALU chain: add r3, then consumer of r3 in the following four cycles
    applyStimulus(1, 1, 0, 3, 0, 0, 2'b00);
    checkOutput("alu_fire", issue_fire_o, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 3, 0, 2'b01);
    checkOutput("alu_sel1", fwd_sel_o, 4'b0001);
    checkOutput("alu_haz", hazard_o, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 3, 0, 2'b01);
    checkOutput("alu_sel2", fwd_sel_o, 4'b0010);
    tick();
    applyStimulus(1, 0, 0, 0, 3, 0, 2'b01);
    checkOutput("alu_sel3", fwd_sel_o, 4'b0011);
    tick();
    applyStimulus(1, 0, 0, 0, 3, 0, 2'b01);
    checkOutput("alu_sel0", fwd_sel_o, 4'b0000);
    tick();

    // Load-use on port 1
    applyStimulus(1, 1, 1, 5, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 5, 2'b10);
    checkOutput("lu_haz", hazard_o, 1);
    checkOutput("lu_fire", issue_fire_o, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 5, 2'b10);
    checkOutput("lu_cnt", stall_cnt_o, 1);
    checkOutput("lu_sel", fwd_sel_o, 4'b1000);
    checkOutput("lu_haz2", hazard_o, 0);
    checkOutput("lu_fire2", issue_fire_o, 1);
    tick();

    // r4 in stage 1 and 3: youngest wins; r0 on port 1 never forwards
    applyStimulus(1, 1, 0, 4, 0, 0, 2'b00); tick();
    applyStimulus(1, 1, 0, 7, 0, 0, 2'b00); tick();
    applyStimulus(1, 1, 0, 4, 0, 0, 2'b00); tick();
    applyStimulus(1, 0, 0, 0, 4, 0, 2'b11);
    checkOutput("pri_sel", fwd_sel_o, 4'b0001);
    checkOutput("pri_haz", hazard_o, 0);
    tick();

    // lw r4 younger than ALU r4: must stall rather than take the older ALU result
    applyStimulus(1, 1, 0, 4, 0, 0, 2'b00); tick();
    applyStimulus(1, 1, 1, 4, 0, 0, 2'b00); tick();
    applyStimulus(1, 0, 0, 0, 4, 0, 2'b01);
    checkOutput("nofall_haz", hazard_o, 1);
    checkOutput("nofall_fire", issue_fire_o, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 4, 0, 2'b01);
    checkOutput("nofall_sel", fwd_sel_o, 4'b0010);
    checkOutput("nofall_cnt", stall_cnt_o, 2);
    checkOutput("nofall_fire2", issue_fire_o, 1);
    tick();

    // wen=0 and dst=r0 entries must not match
    applyStimulus(1, 0, 0, 6, 0, 0, 2'b00); tick();
    applyStimulus(1, 1, 0, 0, 6, 0, 2'b01);
    checkOutput("nowen_sel", fwd_sel_o, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 2'b01);
    checkOutput("r0_sel", fwd_sel_o, 0);
    tick();

    // Hold freezes state and counter during a load-use stall
    applyStimulus(1, 1, 1, 9, 0, 0, 2'b00); tick();
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 9, 0, 2'b01);
      checkOutput("hold_haz", hazard_o, 1);
      checkOutput("hold_fire", issue_fire_o, 0);
      checkOutput("hold_cnt", stall_cnt_o, 2);
      tick();
    end
    hold_i = 1'b0;
    applyStimulus(1, 0, 0, 0, 9, 0, 2'b01);
    checkOutput("rel_haz", hazard_o, 1);
    checkOutput("rel_cnt0", stall_cnt_o, 2);
    tick();
    applyStimulus(1, 0, 0, 0, 9, 0, 2'b01);
    checkOutput("rel_cnt1", stall_cnt_o, 3);
    checkOutput("rel_sel", fwd_sel_o, 4'b0010);
    tick();

    // Flush with pending hazard: add r11, lw r10, then consumer flushed
    applyStimulus(1, 1, 0, 11, 0, 0, 2'b00); tick();
    applyStimulus(1, 1, 1, 10, 0, 0, 2'b00); tick();
    applyStimulus(1, 0, 0, 0, 10, 11, 2'b11);
    checkOutput("fl_pre_haz", hazard_o, 1);
    flush_i = 1'b1;
    #1;
    checkOutput("fl_haz", hazard_o, 0);
    checkOutput("fl_fire", issue_fire_o, 0);
    tick();
    flush_i = 1'b0;
    applyStimulus(1, 0, 0, 0, 10, 11, 2'b11);
    checkOutput("fl_cnt", stall_cnt_o, 3);
    checkOutput("fl_sel", fwd_sel_o, 4'b1100);
    checkOutput("fl_haz2", hazard_o, 0);
    tick();

    // Back-to-back load-use chain to saturate the 4-bit counter
    expCnt = 3;
    applyStimulus(1, 1, 1, 12, 0, 0, 2'b00); tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 1, 12, 12, 0, 2'b01);
      checkOutput("sat_haz", hazard_o, 1);
      tick();
      expCnt = (expCnt < 15) ? expCnt + 1 : 15;
      applyStimulus(1, 1, 1, 12, 12, 0, 2'b01);
      checkOutput("sat_fire", issue_fire_o, 1);
      checkOutput("sat_cnt", stall_cnt_o, expCnt);
      tick();
    end
    checkOutput("sat_final", stall_cnt_o, 15);

    // Asynchronous reset mid-run with three valid entries and a live hazard
    applyStimulus(1, 1, 0, 1, 0, 0, 2'b00); tick();
    applyStimulus(1, 1, 0, 2, 0, 0, 2'b00); tick();
    applyStimulus(1, 1, 1, 3, 0, 0, 2'b00); tick();
    applyStimulus(1, 0, 0, 0, 3, 1, 2'b11);
    checkOutput("mid_haz", hazard_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sel", fwd_sel_o, 0);
    checkOutput("mid_rst_haz", hazard_o, 0);
    checkOutput("mid_rst_cnt", stall_cnt_o, 0);
    #3 rst_n = 1'b1;
    tick();
    applyStimulus(1, 0, 0, 0, 3, 1, 2'b11);
    checkOutput("post_rst_sel", fwd_sel_o, 0);
    checkOutput("post_rst_fire", issue_fire_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
